// File: rtl/mod_count_detector.sv
// Serial ones/zeros residue monitor with Moore match flags.
// Optional framed mode is compiled in with `define MOD_COUNT_FRAME_EN.
module mod_count_detector #(
  parameter int MOD_1     = 2,
  parameter int MOD_0     = 2,
  parameter int TGT_1     = 0,
  parameter int TGT_0     = 0,
  parameter int FRAME_LEN = 8,
  localparam int W1 = $clog2(MOD_1),
  localparam int W0 = $clog2(MOD_0)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          clear,
  output logic          detected_1,
  output logic          detected_0,
  output logic [W1-1:0] count_1,
  output logic [W0-1:0] count_0
`ifdef MOD_COUNT_FRAME_EN
  ,
  output logic          frame_done,
  output logic          frame_det_1,
  output logic          frame_det_0
`endif
);

  generate
    if (MOD_1 < 2) begin : g_err_mod_1
      $error("mod_count_detector: MOD_1 must be >= 2");
    end
    if (MOD_0 < 2) begin : g_err_mod_0
      $error("mod_count_detector: MOD_0 must be >= 2");
    end
    if (TGT_1 < 0 || TGT_1 >= MOD_1) begin : g_err_tgt_1
      $error("mod_count_detector: TGT_1 must be in 0..MOD_1-1");
    end
    if (TGT_0 < 0 || TGT_0 >= MOD_0) begin : g_err_tgt_0
      $error("mod_count_detector: TGT_0 must be in 0..MOD_0-1");
    end
    if (FRAME_LEN < 1) begin : g_err_frame_len
      $error("mod_count_detector: FRAME_LEN must be >= 1");
    end
  endgenerate

  localparam logic [W1-1:0] MAX_1   = W1'(MOD_1 - 1);
  localparam logic [W0-1:0] MAX_0   = W0'(MOD_0 - 1);
  localparam logic [W1-1:0] TGT_1_W = W1'(TGT_1);
  localparam logic [W0-1:0] TGT_0_W = W0'(TGT_0);

  logic [W1-1:0] count_1_reg, count_1_next, inc_1;
  logic [W0-1:0] count_0_reg, count_0_next, inc_0;

`ifdef MOD_COUNT_FRAME_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);

  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          frame_done_reg, frame_done_next;
  logic          frame_det_1_reg, frame_det_1_next;
  logic          frame_det_0_reg, frame_det_0_next;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_1_reg     <= '0;
      count_0_reg     <= '0;
`ifdef MOD_COUNT_FRAME_EN
      frame_cnt_reg   <= '0;
      frame_done_reg  <= 1'b0;
      frame_det_1_reg <= 1'b0;
      frame_det_0_reg <= 1'b0;
`endif
    end else begin
      count_1_reg     <= count_1_next;
      count_0_reg     <= count_0_next;
`ifdef MOD_COUNT_FRAME_EN
      frame_cnt_reg   <= frame_cnt_next;
      frame_done_reg  <= frame_done_next;
      frame_det_1_reg <= frame_det_1_next;
      frame_det_0_reg <= frame_det_0_next;
`endif
    end
  end

  // Next state; '>=' on the wrap test lets an out-of-range residue fall back to 0
  always_comb begin
    inc_1        = (count_1_reg >= MAX_1) ? '0 : count_1_reg + W1'(1);
    inc_0        = (count_0_reg >= MAX_0) ? '0 : count_0_reg + W0'(1);
    count_1_next = count_1_reg;
    count_0_next = count_0_reg;
`ifdef MOD_COUNT_FRAME_EN
    frame_cnt_next   = frame_cnt_reg;
    frame_done_next  = 1'b0;
    frame_det_1_next = frame_det_1_reg;
    frame_det_0_next = frame_det_0_reg;
`endif
    if (clear) begin
      count_1_next = '0;
      count_0_next = '0;
`ifdef MOD_COUNT_FRAME_EN
      frame_cnt_next   = '0;
      frame_det_1_next = 1'b0;
      frame_det_0_next = 1'b0;
`endif
    end else if (in_valid) begin
      if (in_bit) begin
        count_1_next = inc_1;
      end else begin
        count_0_next = inc_0;
      end
`ifdef MOD_COUNT_FRAME_EN
      // Last bit of a frame: snapshot the post-update match, then restart from zero
      if (frame_cnt_reg >= F_LAST) begin
        frame_det_1_next = (count_1_next == TGT_1_W);
        frame_det_0_next = (count_0_next == TGT_0_W);
        frame_done_next  = 1'b1;
        count_1_next     = '0;
        count_0_next     = '0;
        frame_cnt_next   = '0;
      end else begin
        frame_cnt_next = frame_cnt_reg + FW'(1);
      end
`endif
    end
  end

  // Moore outputs
  always_comb begin
    detected_1 = (count_1_reg == TGT_1_W);
    detected_0 = (count_0_reg == TGT_0_W);
  end

  assign count_1 = count_1_reg;
  assign count_0 = count_0_reg;

`ifdef MOD_COUNT_FRAME_EN
  assign frame_done  = frame_done_reg;
  assign frame_det_1 = frame_det_1_reg;
  assign frame_det_0 = frame_det_0_reg;
`endif

endmodule

// File: tb/tb_mod_count_detector.sv
// Randomised self-checking bench for mod_count_detector against a count-and-modulo model.
// Works with or without MOD_COUNT_FRAME_EN defined.
module tb_mod_count_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, in_valid, in_bit, clear;
  logic chk_en = 1'b0;
  int checks = 0;
  int failures = 0;

  // Instance configurations: A defaults/FRAME_LEN 4, B mod3 tgt2, C mod5/3, D defaults/FRAME_LEN 1
  int m1   [4] = '{2, 3, 5, 2};
  int m0   [4] = '{2, 2, 3, 2};
  int t1   [4] = '{0, 2, 4, 0};
  int t0   [4] = '{0, 0, 1, 0};

  logic [0:0] a_c1, a_c0;
  logic [1:0] b_c1;
  logic [0:0] b_c0;
  logic [2:0] c_c1;
  logic [1:0] c_c0;
  logic [0:0] d_c1, d_c0;
  logic a_d1, a_d0, b_d1, b_d0, c_d1, c_d0, d_d1, d_d0;

  logic [31:0] act_c1 [4];
  logic [31:0] act_c0 [4];
  logic [31:0] act_d1 [4];
  logic [31:0] act_d0 [4];

  int m_ones  [4];
  int m_zeros [4];

`ifdef MOD_COUNT_FRAME_EN
  int flen [4] = '{4, 8, 3, 1};
  logic a_fd, a_f1, a_f0, b_fd, b_f1, b_f0, c_fd, c_f1, c_f0, d_fd, d_f1, d_f0;
  logic [31:0] act_fd [4];
  logic [31:0] act_f1 [4];
  logic [31:0] act_f0 [4];
  int   m_fbits [4];
  logic m_fd    [4];
  logic m_fdet1 [4];
  logic m_fdet0 [4];
`endif

  mod_count_detector #(.FRAME_LEN(4)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .detected_1(a_d1), .detected_0(a_d0), .count_1(a_c1), .count_0(a_c0)
`ifdef MOD_COUNT_FRAME_EN
    , .frame_done(a_fd), .frame_det_1(a_f1), .frame_det_0(a_f0)
`endif
  );

  mod_count_detector #(.MOD_1(3), .TGT_1(2), .FRAME_LEN(8)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .detected_1(b_d1), .detected_0(b_d0), .count_1(b_c1), .count_0(b_c0)
`ifdef MOD_COUNT_FRAME_EN
    , .frame_done(b_fd), .frame_det_1(b_f1), .frame_det_0(b_f0)
`endif
  );

  mod_count_detector #(.MOD_1(5), .MOD_0(3), .TGT_1(4), .TGT_0(1), .FRAME_LEN(3)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .detected_1(c_d1), .detected_0(c_d0), .count_1(c_c1), .count_0(c_c0)
`ifdef MOD_COUNT_FRAME_EN
    , .frame_done(c_fd), .frame_det_1(c_f1), .frame_det_0(c_f0)
`endif
  );

  mod_count_detector #(.FRAME_LEN(1)) u_d (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .detected_1(d_d1), .detected_0(d_d0), .count_1(d_c1), .count_0(d_c0)
`ifdef MOD_COUNT_FRAME_EN
    , .frame_done(d_fd), .frame_det_1(d_f1), .frame_det_0(d_f0)
`endif
  );

  always_comb begin
    act_c1[0] = 32'(a_c1); act_c0[0] = 32'(a_c0); act_d1[0] = 32'(a_d1); act_d0[0] = 32'(a_d0);
    act_c1[1] = 32'(b_c1); act_c0[1] = 32'(b_c0); act_d1[1] = 32'(b_d1); act_d0[1] = 32'(b_d0);
    act_c1[2] = 32'(c_c1); act_c0[2] = 32'(c_c0); act_d1[2] = 32'(c_d1); act_d0[2] = 32'(c_d0);
    act_c1[3] = 32'(d_c1); act_c0[3] = 32'(d_c0); act_d1[3] = 32'(d_d1); act_d0[3] = 32'(d_d0);
`ifdef MOD_COUNT_FRAME_EN
    act_fd[0] = 32'(a_fd); act_f1[0] = 32'(a_f1); act_f0[0] = 32'(a_f0);
    act_fd[1] = 32'(b_fd); act_f1[1] = 32'(b_f1); act_f0[1] = 32'(b_f0);
    act_fd[2] = 32'(c_fd); act_f1[2] = 32'(c_f1); act_f0[2] = 32'(c_f0);
    act_fd[3] = 32'(d_fd); act_f1[3] = 32'(d_f1); act_f0[3] = 32'(d_f0);
`endif
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Model: raw ones/zeros totals since the last restart; residues are totals modulo the base
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ones[i]  = 0;
      m_zeros[i] = 0;
`ifdef MOD_COUNT_FRAME_EN
      m_fbits[i] = 0;
      m_fd[i]    = 1'b0;
      m_fdet1[i] = 1'b0;
      m_fdet0[i] = 1'b0;
`endif
    end
  endtask

  task automatic model_step();
    if (!reset_n) return;
    for (int i = 0; i < 4; i++) begin
`ifdef MOD_COUNT_FRAME_EN
      m_fd[i] = 1'b0;
`endif
      if (clear) begin
        m_ones[i]  = 0;
        m_zeros[i] = 0;
`ifdef MOD_COUNT_FRAME_EN
        m_fbits[i] = 0;
        m_fdet1[i] = 1'b0;
        m_fdet0[i] = 1'b0;
`endif
      end else if (in_valid) begin
        if (in_bit) m_ones[i]++;
        else        m_zeros[i]++;
`ifdef MOD_COUNT_FRAME_EN
        m_fbits[i]++;
        if (m_fbits[i] == flen[i]) begin
          m_fdet1[i] = ((m_ones[i] % m1[i]) == t1[i]);
          m_fdet0[i] = ((m_zeros[i] % m0[i]) == t0[i]);
          m_fd[i]    = 1'b1;
          m_ones[i]  = 0;
          m_zeros[i] = 0;
          m_fbits[i] = 0;
        end
`endif
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk("model_count_1", i, act_c1[i], 32'(m_ones[i] % m1[i]));
      chk("model_count_0", i, act_c0[i], 32'(m_zeros[i] % m0[i]));
      chk("model_detected_1", i, act_d1[i], 32'((m_ones[i] % m1[i]) == t1[i]));
      chk("model_detected_0", i, act_d0[i], 32'((m_zeros[i] % m0[i]) == t0[i]));
`ifdef MOD_COUNT_FRAME_EN
      chk("model_frame_done", i, act_fd[i], 32'(m_fd[i]));
      chk("model_frame_det_1", i, act_f1[i], 32'(m_fdet1[i]));
      chk("model_frame_det_0", i, act_f0[i], 32'(m_fdet0[i]));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check_model();
  end

  task automatic cyc(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    $display("txn t=%0t rst_n=%b v=%b b=%b clr=%b A=(%0d,%0d,%b,%b) B=(%0d,%0d) C=(%0d,%0d)",
             $time, reset_n, v, b, c, a_c1, a_c0, a_d1, a_d0, b_c1, b_c0, c_c1, c_c0);
  endtask

  int t2_bits [4] = '{1, 0, 1, 1};
  int t2_d1   [4] = '{0, 0, 1, 0};
  int t2_d0   [4] = '{1, 0, 0, 0};
  int t3_c1   [5] = '{1, 2, 0, 1, 2};
  int t3_d1   [5] = '{0, 1, 0, 0, 1};

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset state
    chk("t1_count_1", 0, act_c1[0], 0);
    chk("t1_count_0", 0, act_c0[0], 0);
    chk("t1_detected_1", 0, act_d1[0], 1);
    chk("t1_detected_0", 0, act_d0[0], 1);

    // Bits 1,0,1,1 on defaults
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, t2_bits[k][0], 1'b0);
`ifdef MOD_COUNT_FRAME_EN
      if (k == 3) begin
        chk("t2_detected_1", 0, act_d1[0], 1);
        chk("t2_detected_0", 0, act_d0[0], 1);
        continue;
      end
`endif
      chk("t2_detected_1", 0, act_d1[0], 32'(t2_d1[k]));
      chk("t2_detected_0", 0, act_d0[0], 32'(t2_d0[k]));
    end

    // MOD_1=3, TGT_1=2: five ones
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("t3_count_1", 1, act_c1[1], 32'(t3_c1[k]));
      chk("t3_detected_1", 1, act_d1[1], 32'(t3_d1[k]));
    end

    // Idle with toggling in_bit, then clear beats a valid one
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, k[0], 1'b0);
      chk("t4_hold_count_1", 0, act_c1[0], 1);
      chk("t4_hold_count_0", 0, act_c0[0], 0);
      chk("t4_hold_count_1", 1, act_c1[1], 2);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("t4_clear_count_1", 0, act_c1[0], 0);
    chk("t4_clear_count_0", 0, act_c0[0], 0);
    chk("t4_clear_detected_1", 0, act_d1[0], 1);
    chk("t4_clear_count_1", 1, act_c1[1], 0);

`ifdef MOD_COUNT_FRAME_EN
    // Frame of 1,1,0,1 on FRAME_LEN=4
    cyc(1'b1, 1'b1, 1'b0); chk("t5_frame_done_early", 0, act_fd[0], 0);
    cyc(1'b1, 1'b1, 1'b0); chk("t5_frame_done_early", 0, act_fd[0], 0);
    cyc(1'b1, 1'b0, 1'b0); chk("t5_frame_done_early", 0, act_fd[0], 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_frame_done", 0, act_fd[0], 1);
    chk("t5_frame_det_1", 0, act_f1[0], 0);
    chk("t5_frame_det_0", 0, act_f0[0], 0);
    chk("t5_count_1", 0, act_c1[0], 0);
    chk("t5_count_0", 0, act_c0[0], 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t5_frame_done_pulse", 0, act_fd[0], 0);
    chk("t5_frame_det_1_hold", 0, act_f1[0], 0);
    // Frame of four zeros sets both held flags
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
    chk("t6_frame_det_1", 0, act_f1[0], 1);
    chk("t6_frame_det_0", 0, act_f0[0], 1);
`endif

    // Two bits in, then asynchronous reset between edges
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_count_1", 0, act_c1[0], 0);
    chk("t6_async_count_0", 0, act_c0[0], 0);
    chk("t6_async_detected_1", 0, act_d1[0], 1);
    chk("t6_async_detected_0", 0, act_d0[0], 1);
    chk("t6_async_count_1", 2, act_c1[2], 0);
`ifdef MOD_COUNT_FRAME_EN
    chk("t6_async_frame_det_1", 0, act_f1[0], 0);
    chk("t6_async_frame_det_0", 0, act_f0[0], 0);
    chk("t6_async_frame_done", 0, act_fd[0], 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
`ifdef MOD_COUNT_FRAME_EN
      chk("t6_frame_done_after_reset", 0, act_fd[0], (k == 3) ? 1 : 0);
`endif
    end

    // Random traffic with occasional clears and asynchronous resets
    for (int n = 0; n < 1500; n++) begin
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        model_reset();
      end
      cyc(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
